pll_lock_qualifier: RTL and testbench

Upstream stage of the PLL-clocked counter. It turns the raw PLL_LOCK flag and the external clken pin into a clean, glitch-free synchronous clock enable (scken) for the counter. Lock is qualified: it must stay stable for a programmable number of pllclk cycles before it is accepted. A lock loss forces a holdoff period and is counted for debug. The block runs entirely in the pllclk domain.

---
 rtl/pll_pkg.sv | 17 +
 rtl/sync_2ff.sv | 18 +
 rtl/pll_lock_qualifier.sv | 113 +++++++++++
 tb/tb_pll_lock_qualifier.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock qualifier: FSM encoding, counter width
// and default qualification/holdoff lengths.
package pll_pkg;

  localparam int STATE_W                = 2;
  localparam int CNT_W                  = 8;
  localparam int LOCK_STABLE_CYCLES_DEF = 16;
  localparam int HOLDOFF_CYCLES_DEF     = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_UNLOCKED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOFF  = 2'd3
  } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-stage synchronizer, async active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_lock_qualifier.sv
// Qualifies raw PLL lock and the external clken pin into a glitch-free,
// registered clock enable for the pllclk-domain counter.
module pll_lock_qualifier
  import pll_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES     = HOLDOFF_CYCLES_DEF,
  parameter int LOSS_CNT_W         = 4
) (
  input  logic                  pllclk,
  input  logic                  rst,
  input  logic                  lock_raw,
  input  logic                  clken_in,
  output logic                  scken,
  output logic                  locked,
  output logic [STATE_W-1:0]    state,
  output logic                  loss_pulse,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam logic [CNT_W-1:0] QMAX = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(HOLDOFF_CYCLES - 1);

  logic lock_s, clken_s;

  sync_2ff u_sync_lock (
    .clk (pllclk),
    .rst (rst),
    .d_i (lock_raw),
    .q_o (lock_s)
  );

  sync_2ff u_sync_clken (
    .clk (pllclk),
    .rst (rst),
    .d_i (clken_in),
    .q_o (clken_s)
  );

  pll_state_e            state_q, state_d;
  logic [CNT_W-1:0]      qcnt_q, qcnt_d;
  logic [CNT_W-1:0]      hcnt_q, hcnt_d;
  logic                  scken_q, scken_d;
  logic                  loss_pulse_q, loss_pulse_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      qcnt_q       <= '0;
      hcnt_q       <= '0;
      scken_q      <= 1'b0;
      loss_pulse_q <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      hcnt_q       <= hcnt_d;
      scken_q      <= scken_d;
      loss_pulse_q <= loss_pulse_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    qcnt_d       = qcnt_q;
    hcnt_d       = hcnt_q;
    loss_pulse_d = 1'b0;
    loss_cnt_d   = loss_cnt_q;
    // Enable uses the current state, so it drops on the LOCKED->HOLDOFF edge.
    scken_d      = (state_q == ST_LOCKED) & lock_s & clken_s;
    unique case (state_q)
      ST_UNLOCKED: begin
        if (lock_s) begin
          state_d = ST_QUALIFY;
          qcnt_d  = '0;
        end
      end
      ST_QUALIFY: begin
        // A dropout wins over completion and discards all progress.
        if (!lock_s)              state_d = ST_UNLOCKED;
        else if (qcnt_q == QMAX)  state_d = ST_LOCKED;
        else                      qcnt_d  = qcnt_q + 1'b1;
      end
      ST_LOCKED: begin
        if (!lock_s) begin
          state_d      = ST_HOLDOFF;
          hcnt_d       = '0;
          loss_pulse_d = 1'b1;
          if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (hcnt_q == HMAX) state_d = ST_UNLOCKED;
        else                hcnt_d  = hcnt_q + 1'b1;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  assign scken      = scken_q;
  assign locked     = (state_q == ST_LOCKED);
  assign state      = state_q;
  assign loss_pulse = loss_pulse_q;
  assign loss_count = loss_cnt_q;

  a_qcnt_bound : assert property (@(posedge pllclk) disable iff (rst) qcnt_q <= QMAX);
  a_hcnt_bound : assert property (@(posedge pllclk) disable iff (rst) hcnt_q <= HMAX);
  a_pulse_hold : assert property (@(posedge pllclk) disable iff (rst)
                                  loss_pulse_q |-> state_q == ST_HOLDOFF);

endmodule

// File: tb/tb_pll_lock_qualifier.sv
// Directed bench for pll_lock_qualifier with default parameters (N=16, H=8, W=4).
module tb_pll_lock_qualifier;

  logic       pllclk = 1'b0;
  logic       rst;
  logic       lock_raw;
  logic       clken_in;
  logic       scken;
  logic       locked;
  logic [1:0] state;
  logic       loss_pulse;
  logic [3:0] loss_count;

  int checks = 0;
  int errors = 0;

  always #5 pllclk = ~pllclk;

  pll_lock_qualifier dut (
    .pllclk     (pllclk),
    .rst        (rst),
    .lock_raw   (lock_raw),
    .clken_in   (clken_in),
    .scken      (scken),
    .locked     (locked),
    .state      (state),
    .loss_pulse (loss_pulse),
    .loss_count (loss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1ns later.
  task automatic step(input int n);
    repeat (n) @(posedge pllclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".scken"}, scken, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".state"}, state, 0);
    chk({tag, ".pulse"}, loss_pulse, 0);
    chk({tag, ".count"}, loss_count, 0);
  endtask

  // Called just after reset release with lock_raw=clken_in=1.
  task automatic qual_from_reset(input string tag);
    for (int e = 1; e <= 18; e++) begin
      step(1);
      chk({tag, ".locked_low"}, locked, 0);
      chk({tag, ".state_pre"}, state, (e <= 2) ? 0 : 1);
    end
    step(1);
    chk({tag, ".locked_e19"}, locked, 1);
    chk({tag, ".state_e19"}, state, 2);
    chk({tag, ".scken_e19"}, scken, 0);
    step(1);
    chk({tag, ".scken_e20"}, scken, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_cnt;

    // 1: reset then steady lock
    rst = 1'b1; lock_raw = 1'b1; clken_in = 1'b1;
    #1;
    chk_all_zero("t1_reset");
    step(3);
    chk_all_zero("t1_reset_held");
    #2 rst = 1'b0;
    qual_from_reset("t1");

    // 2: dropout during qualify
    rst = 1'b1; #1; rst = 1'b0;
    step(11);
    lock_raw = 1'b0;            // sampled low only by edge 12
    step(1);
    lock_raw = 1'b1;
    step(1);                    // edge 13: qcnt=10, lock_s=0
    chk("t2_state_e13", state, 1);
    step(1);                    // edge 14
    chk("t2_state_e14", state, 0);
    for (int e = 15; e <= 30; e++) begin
      step(1);
      chk("t2_requalify", state, 1);
    end
    step(1);                    // edge 31
    chk("t2_locked", locked, 1);
    chk("t2_loss_count", loss_count, 0);
    step(1);
    chk("t2_scken", scken, 1);

    // 3: lock loss while LOCKED
    lock_raw = 1'b0;
    step(2);
    chk("t3_still_locked", state, 2);
    step(1);                    // D3
    chk("t3_state_holdoff", state, 3);
    chk("t3_pulse", loss_pulse, 1);
    chk("t3_count", loss_count, 1);
    chk("t3_scken", scken, 0);
    step(1);                    // D4
    chk("t3_pulse_once", loss_pulse, 0);
    lock_raw = 1'b1;
    for (int e = 5; e <= 10; e++) begin
      step(1);
      chk("t3_in_holdoff", state, 3);
    end
    step(1);                    // D11
    chk("t3_unlocked", state, 0);
    step(1);                    // D12
    chk("t3_qualify", state, 1);
    step(16);                   // D28
    chk("t3_relocked", locked, 1);
    step(1);
    chk("t3_scken_back", scken, 1);

    // 4: clken gating, 0 before edges 1..5, 1 afterwards
    clken_in = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      if (e == 5) clken_in = 1'b1;
      chk("t4_scken", scken, (e >= 3 && e <= 7) ? 0 : 1);
      chk("t4_locked", locked, 1);
    end

    // 5: loss counter saturation
    exp_cnt = 4'd1;
    for (int k = 0; k < 20; k++) begin
      lock_raw = 1'b0;
      step(3);
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
      chk("t5_pulse", loss_pulse, 1);
      chk("t5_count", loss_count, exp_cnt);
      lock_raw = 1'b1;
      step(1);
      chk("t5_pulse_low", loss_pulse, 0);
      step(24);
      chk("t5_relock", locked, 1);
      step(1);
    end
    chk("t5_saturated", loss_count, 15);
    chk("t5_scken", scken, 1);

    // 6: async reset mid-operation
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t6_async");
    step(2);
    #2 rst = 1'b0;
    qual_from_reset("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
